// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side streaming blocks.
package fifo_pkg;
  localparam int DEF_FIFO_DATA_WIDTH = 8;
  localparam int SKID_DEPTH          = 2;
  typedef logic [1:0] skid_cnt_t;
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order skid storage: push appends at tail, pop drops head.
// Caller guarantees no push into a full buffer without a same-cycle pop.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DEF_FIFO_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output skid_cnt_t    count
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  // storage, ring pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a registered-read FIFO into a valid/ready stream.
// Optional word_count handshake counter: define FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_empty,
  output logic                       fifo_read,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_read_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_DATA_WIDTH-1:0] out_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]       word_count
`endif
);

  skid_cnt_t count;
  skid_cnt_t occ;
  logic      inflight;
  logic      pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = (count != '0);

  // Slots committed after this edge: buffered words plus the word in
  // flight, minus the one leaving now. Only pop if one slot stays free,
  // so a word arriving next cycle always has room.
  assign occ       = count + {1'b0, inflight} - {1'b0, pop};
  assign fifo_read = !reset && !fifo_empty && (occ < skid_cnt_t'(SKID_DEPTH));

  // a pop accepted this edge delivers its data on the next edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_read;
  end

  fifo_rd_skid_buf #(.W(FIFO_DATA_WIDTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_read_data),
    .head  (out_data),
    .count (count)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  // downstream handshake counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    word_count <= '0;
    else if (pop) word_count <= word_count + 1'b1;
  end
`endif

endmodule
